// File: rtl/asteroid_move_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : asteroid_pkg
// Description : Shared definitions for the asteroid position-update path.
//               Holds the movement opcodes, the position-mux select codes
//               (shared with the external position mux), the sequencer
//               state enum and the field-edge check used to decide respawn.
// Revision    : 1.0 - initial release
// ============================================================================
package asteroid_pkg;

  // Movement opcodes as stored in the low two bits of a table entry.
  // Bit 1 selects the axis (0 = X, 1 = Y); bit 0 selects the direction
  // (0 = increment, 1 = decrement).
  typedef enum logic [1:0] {
    OP_MAIS_X  = 2'b00,
    OP_MENOS_X = 2'b01,
    OP_MAIS_Y  = 2'b10,
    OP_MENOS_Y = 2'b11
  } opcode_t;

  // Position mux select codes.
  localparam logic [1:0] SEL_RANDOM = 2'b00;
  localparam logic [1:0] SEL_SOMA_X = 2'b01;
  localparam logic [1:0] SEL_SOMA_Y = 2'b10;

  // Sequencer states.
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    LE          = 3'd1,
    DECIDE      = 3'd2,
    ESPERA_RAND = 3'd3,
    ESCREVE     = 3'd4,
    FIM         = 3'd5
  } estado_t;

  // Widest coordinate the edge check accepts; callers zero-extend into it.
  localparam int COORD_MAX_W = 16;

  // Returns 1 when moving the coordinate in the opcode's direction would
  // leave the 0..2^n-1 field. The caller passes the coordinate of the axis
  // the opcode moves along.
  function automatic logic na_borda(
    input logic [COORD_MAX_W-1:0] coord,
    input int unsigned            n,
    input opcode_t                op
  );
    logic [COORD_MAX_W-1:0] lim;
    lim = (COORD_MAX_W'(1) << n) - COORD_MAX_W'(1);
    if (op[0]) begin
      return (coord == '0);
    end
    return (coord == lim);
  endfunction

endpackage : asteroid_pkg
`default_nettype wire

// File: rtl/asteroid_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : asteroid_move_ctrl_if
// Description : Bundles the sequencer's control, table, random-source and
//               datapath-steering signals.
//   iniciar          start-sweep pulse
//   mem_dado         table read data {x, y, opcode}, 1-cycle read latency
//   random_valid     random source outputs are stable
//   mem_endereco     table address (read and write)
//   mem_we           table write enable
//   select_mux_pos   position mux select
//   coord_atual      adder operand
//   soma_decrementa  adder mode (1 = decrement)
//   random_req       random position request
//   ocupado          sweep in progress
//   pronto           one-cycle sweep-done pulse
//   contagem_respawn respawns in the last / current sweep
//   Modport slave is the sequencer; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface asteroid_move_ctrl_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 3
);

  logic                iniciar;
  logic [2*N+1:0]      mem_dado;
  logic                random_valid;
  logic [ADDR_W-1:0]   mem_endereco;
  logic                mem_we;
  logic [1:0]          select_mux_pos;
  logic [N-1:0]        coord_atual;
  logic                soma_decrementa;
  logic                random_req;
  logic                ocupado;
  logic                pronto;
  logic [ADDR_W:0]     contagem_respawn;

  modport slave (
    input  iniciar,
    input  mem_dado,
    input  random_valid,
    output mem_endereco,
    output mem_we,
    output select_mux_pos,
    output coord_atual,
    output soma_decrementa,
    output random_req,
    output ocupado,
    output pronto,
    output contagem_respawn
  );

  modport master (
    output iniciar,
    output mem_dado,
    output random_valid,
    input  mem_endereco,
    input  mem_we,
    input  select_mux_pos,
    input  coord_atual,
    input  soma_decrementa,
    input  random_req,
    input  ocupado,
    input  pronto,
    input  contagem_respawn
  );

endinterface : asteroid_move_ctrl_if
`default_nettype wire

// File: rtl/asteroid_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asteroid_move_ctrl
// Description : Sequencer for the asteroid position-update datapath. Each
//               accepted iniciar sweeps the DEPTH-entry table: read entry,
//               decode opcode / check field edge, optionally fetch a random
//               position, then write the entry back.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      asteroid_move_ctrl_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module asteroid_move_ctrl
  import asteroid_pkg::*;
#(
  parameter int N      = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  asteroid_move_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_ultimo   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_end_um   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_cont_um  = (ADDR_W + 1)'(1);
  localparam int unsigned       c_n        = N;

  // Table entry fields, valid during DECIDE.
  logic [N-1:0] w_x;
  logic [N-1:0] w_y;
  opcode_t      w_op;
  logic [N-1:0] w_coord;
  logic         w_borda;

  assign w_x     = bus.mem_dado[2*N+1:N+2];
  assign w_y     = bus.mem_dado[N+1:2];
  assign w_op    = opcode_t'(bus.mem_dado[1:0]);
  assign w_coord = w_op[1] ? w_y : w_x;
  assign w_borda = na_borda(COORD_MAX_W'(w_coord), c_n, w_op);

  estado_t           r_estado;
  logic [ADDR_W-1:0] r_endereco;
  logic              r_we;
  logic [1:0]        r_sel;
  logic [N-1:0]      r_coord;
  logic              r_dec;
  logic              r_req;
  logic              r_ocupado;
  logic              r_pronto;
  logic [ADDR_W:0]   r_cont;

  // All outputs are registered: each one is set on the edge that enters
  // the state in which it must be asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= OCIOSO;
      r_endereco <= '0;
      r_we       <= 1'b0;
      r_sel      <= SEL_RANDOM;
      r_coord    <= '0;
      r_dec      <= 1'b0;
      r_req      <= 1'b0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
      r_cont     <= '0;
    end else begin
      r_we     <= 1'b0;
      r_pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            r_estado   <= LE;
            r_endereco <= '0;
            r_cont     <= '0;
            r_ocupado  <= 1'b1;
          end
        end

        LE: begin
          r_estado <= DECIDE;
        end

        DECIDE: begin
          r_dec <= w_op[0];
          if (w_borda) begin
            // Respawn: the mux takes the random source, operand unused.
            r_sel    <= SEL_RANDOM;
            r_coord  <= '0;
            r_req    <= 1'b1;
            r_estado <= ESPERA_RAND;
          end else begin
            r_sel    <= w_op[1] ? SEL_SOMA_Y : SEL_SOMA_X;
            r_coord  <= w_coord;
            r_we     <= 1'b1;
            r_estado <= ESCREVE;
          end
        end

        ESPERA_RAND: begin
          // The request drops together with the write, so the random
          // source stays stable through the write cycle.
          if (bus.random_valid) begin
            r_cont   <= r_cont + c_cont_um;
            r_req    <= 1'b0;
            r_we     <= 1'b1;
            r_estado <= ESCREVE;
          end
        end

        ESCREVE: begin
          if (r_endereco == c_ultimo) begin
            r_pronto <= 1'b1;
            r_estado <= FIM;
          end else begin
            r_endereco <= r_endereco + c_end_um;
            r_estado   <= LE;
          end
        end

        FIM: begin
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end

        default: begin
          r_ocupado <= 1'b0;
          r_req     <= 1'b0;
          r_estado  <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.mem_endereco     = r_endereco;
  assign bus.mem_we           = r_we;
  assign bus.select_mux_pos   = r_sel;
  assign bus.coord_atual      = r_coord;
  assign bus.soma_decrementa  = r_dec;
  assign bus.random_req       = r_req;
  assign bus.ocupado          = r_ocupado;
  assign bus.pronto           = r_pronto;
  assign bus.contagem_respawn = r_cont;

endmodule : asteroid_move_ctrl
`default_nettype wire

// File: tb/tb_asteroid_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_asteroid_move_ctrl
// Description : Scoreboard bench for asteroid_move_ctrl. Sweeps push the
//               hand-computed expected write of every entry; a monitor pops
//               and compares on every mem_we, including the number of
//               cycles random_req was held before that write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asteroid_move_ctrl;

  localparam int N      = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef struct {
    int addr;
    int sel;
    int coord;
    int dec;
    int w;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  asteroid_move_ctrl_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  asteroid_move_ctrl #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_writes = 0;
  int   n_pronto = 0;
  int   req_run  = 0;
  int   rand_delay = 4;
  bit   spam_valid = 1'b0;
  int   req_cnt  = 0;

  logic [2*N+1:0] tbl [DEPTH];
  exp_t           exp_tbl [DEPTH];
  exp_t           sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  always @(posedge clock) cyc++;

  // Synchronous-read table model.
  always @(posedge clock) bus.mem_dado <= tbl[bus.mem_endereco];

  // Random source: answers random_req after rand_delay request cycles.
  always @(negedge clock) begin
    if (!reset_n) begin
      req_cnt = 0;
      bus.random_valid = 1'b0;
    end else if (bus.random_req) begin
      req_cnt++;
      bus.random_valid = (req_cnt >= rand_delay) ? 1'b1 : 1'b0;
    end else begin
      req_cnt = 0;
      bus.random_valid = spam_valid;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    if (!reset_n) begin
      req_run = 0;
    end else begin
      if (bus.random_req) req_run++;
      if (bus.pronto) n_pronto++;
      if (bus.mem_we) begin
        n_writes++;
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'(bus.mem_endereco), 32'hFFFF);
        end else begin
          exp_t e;
          logic [31:0] act, expv;
          e = sb_q.pop_front();
          act  = (32'(bus.mem_endereco) << 16) | (32'(bus.select_mux_pos) << 12) |
                 (32'(bus.coord_atual) << 8) | (32'(bus.soma_decrementa) << 4) | 32'(req_run & 15);
          expv = (32'(e.addr) << 16) | (32'(e.sel) << 12) | (32'(e.coord) << 8) |
                 (32'(e.dec) << 4) | 32'(e.w & 15);
          check($sformatf("write_a%0d{addr,sel,coord,dec,wait}", e.addr), act, expv);
        end
        req_run = 0;
      end
    end
  end

  task automatic set_entry(input int a, input int x, input int y, input int op,
                           input int sel, input int coord, input int dec, input int w);
    tbl[a] = {4'(x), 4'(y), 2'(op)};
    exp_tbl[a] = '{addr: a, sel: sel, coord: coord, dec: dec, w: w};
  endtask

  task automatic run_sweep(input string tag, input int exp_lat, input int exp_resp, input bit pulse_mid);
    int start, lat, occ;
    bit done;
    for (int i = 0; i < DEPTH; i++) sb_q.push_back(exp_tbl[i]);
    n_writes = 0;
    n_pronto = 0;
    occ = 0;
    lat = -1;
    done = 1'b0;
    start = cyc;
    bus.iniciar = 1'b1;
    for (int j = 0; j < 400 && !done; j++) begin
      @(negedge clock);
      if (cyc - start == 1) bus.iniciar = 1'b0;
      if (pulse_mid && (cyc - start == 5)) bus.iniciar = 1'b1;
      if (pulse_mid && (cyc - start == 6)) bus.iniciar = 1'b0;
      if (bus.ocupado) occ++;
      if (bus.pronto) begin
        lat = cyc - start;
        check({tag, "_respawn_at_pronto"}, 32'(bus.contagem_respawn), 32'(exp_resp));
        done = 1'b1;
      end
    end
    bus.iniciar = 1'b0;
    check({tag, "_pronto_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ocupado_cycles"}, 32'(occ), 32'(exp_lat));
    repeat (3) @(negedge clock);
    check({tag, "_write_count"}, 32'(n_writes), 32'(DEPTH));
    check({tag, "_pronto_pulses"}, 32'(n_pronto), 32'd1);
    check({tag, "_idle_after"}, {31'd0, bus.ocupado}, 32'd0);
    check({tag, "_respawn_hold"}, 32'(bus.contagem_respawn), 32'(exp_resp));
    check({tag, "_scoreboard_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin : stim
    bit seen;
    bus.iniciar = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          {16'd0, bus.mem_endereco, bus.mem_we, bus.select_mux_pos, bus.coord_atual,
           bus.soma_decrementa, bus.random_req, bus.ocupado, bus.pronto, bus.contagem_respawn}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Sweep A: no edges, spurious random_valid and mid-sweep iniciar ignored.
    set_entry(0,  3,  5, 0, 1,  3, 0, 0);
    set_entry(1,  4,  0, 2, 2,  0, 0, 0);
    set_entry(2,  7,  7, 1, 1,  7, 1, 0);
    set_entry(3,  2,  9, 3, 2,  9, 1, 0);
    set_entry(4,  0, 15, 0, 1,  0, 0, 0);
    set_entry(5, 15,  0, 1, 1, 15, 1, 0);
    set_entry(6,  8, 14, 2, 2, 14, 0, 0);
    set_entry(7,  1,  1, 3, 2,  1, 1, 0);
    spam_valid = 1'b1;
    run_sweep("sweepA", 25, 0, 1'b1);
    spam_valid = 1'b0;

    // Sweep B: four respawns, each waiting 4 cycles.
    rand_delay = 4;
    set_entry(0, 15,  2, 0, 0,  0, 0, 4);
    set_entry(1,  4,  0, 3, 0,  0, 1, 4);
    set_entry(2,  0,  3, 1, 0,  0, 1, 4);
    set_entry(3,  5, 15, 2, 0,  0, 0, 4);
    set_entry(4,  4,  0, 2, 2,  0, 0, 0);
    set_entry(5, 14,  6, 0, 1, 14, 0, 0);
    set_entry(6,  1,  6, 1, 1,  1, 1, 0);
    set_entry(7,  6,  1, 3, 2,  1, 1, 0);
    run_sweep("sweepB", 41, 4, 1'b0);

    // Sweep C: every entry respawns, count reaches DEPTH.
    rand_delay = 1;
    set_entry(0, 15,  3, 0, 0, 0, 0, 1);
    set_entry(1,  0,  3, 1, 0, 0, 1, 1);
    set_entry(2,  3, 15, 2, 0, 0, 0, 1);
    set_entry(3,  3,  0, 3, 0, 0, 1, 1);
    set_entry(4, 15, 15, 0, 0, 0, 0, 1);
    set_entry(5,  0,  0, 1, 0, 0, 1, 1);
    set_entry(6,  0, 15, 2, 0, 0, 0, 1);
    set_entry(7, 15,  0, 3, 0, 0, 1, 1);
    run_sweep("sweepC", 33, 8, 1'b0);
    repeat (5) @(negedge clock);
    check("respawn_hold_long", 32'(bus.contagem_respawn), 32'd8);

    // Reset while waiting in ESPERA_RAND on entry 1.
    rand_delay = 1;
    set_entry(0, 15, 2, 0, 0, 0, 0, 1);
    set_entry(1,  0, 4, 1, 0, 0, 1, 1);
    sb_q.push_back(exp_tbl[0]);
    n_writes = 0;
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 50 && !seen; j++) begin
      @(negedge clock);
      if (n_writes >= 1) seen = 1'b1;
    end
    rand_delay = 100;
    check("rst_first_write_seen", {31'd0, seen}, 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 50 && !seen; j++) begin
      @(negedge clock);
      if (bus.random_req) seen = 1'b1;
    end
    check("rst_req_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midsweep_reset_outputs",
          {16'd0, bus.mem_endereco, bus.mem_we, bus.select_mux_pos, bus.coord_atual,
           bus.soma_decrementa, bus.random_req, bus.ocupado, bus.pronto, bus.contagem_respawn}, 32'd0);
    n_writes = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("no_write_after_reset", 32'(n_writes), 32'd0);
    check("idle_after_reset", {31'd0, bus.ocupado}, 32'd0);
    check("rst_scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_asteroid_move_ctrl
`default_nettype wire
